// File: rtl/movimiento_pkg.sv
// ---------------------------------------------------------------------------
// movimiento_pkg
// Shared definitions for the movement-controller stepper stages.
//   ST_IDLE..ST_PULSE_LO : FSM state encodings used by motor_step_driver
//   state_e              : enumerated FSM state type built on those encodings
//   DIR_POS / DIR_NEG    : values driven on the DIR pin for each direction
// ---------------------------------------------------------------------------
package movimiento_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETUP    = 2'd1;
    localparam logic [1:0] ST_PULSE_HI = 2'd2;
    localparam logic [1:0] ST_PULSE_LO = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = ST_IDLE,
        S_SETUP    = ST_SETUP,
        S_PULSE_HI = ST_PULSE_HI,
        S_PULSE_LO = ST_PULSE_LO
    } state_e;

    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/motor_step_driver_step_timer.sv
// ---------------------------------------------------------------------------
// step_timer
// Cycle counter shared by the DIR setup hold and the STEP pulse/period timing.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   en           : count up by one per cycle
//   clear        : force the count to 0 (wins over en)
//   load         : capture period_in as the current period length
//   period_in    : period length in cycles, already limited to the minimum
//   count        : current count (cycles since the last clear)
//   pulse_done   : count is on the last STEP-high cycle
//   period_done  : count is on the last cycle of the loaded period
// ---------------------------------------------------------------------------
module step_timer #(
    parameter int PW      = 16,
    parameter int PULSE_W = 50
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clear,
    input  logic          load,
    input  logic [PW-1:0] period_in,
    output logic [PW-1:0] count,
    output logic          pulse_done,
    output logic          period_done
);

    logic [PW-1:0] count_q, count_d;
    logic [PW-1:0] period_q, period_d;

    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + PW'(1);
        end
        if (load) begin
            period_d = period_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            period_q <= '0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
        end
    end

    // The count is cleared on the STEP rising edge, so count == k means k
    // cycles have passed since the rise.
    assign count       = count_q;
    assign pulse_done  = (count_q == PW'(PULSE_W - 1));
    assign period_done = (count_q == period_q - PW'(1));

endmodule

// File: rtl/motor_step_driver.sv
// ---------------------------------------------------------------------------
// motor_step_driver
// Converts one axis' pos/neg move request into STEP/DIR pulses and keeps the
// signed step-count position fed back to the movement controller.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   cmd_pos, cmd_neg  : move requests (both together is a fault)
//   period            : step period in cycles, raised to MIN_PERIOD if shorter
//   pos_min, pos_max  : signed inclusive soft limits
//   zero              : one-cycle homing strobe, position <= 0
//   step, dir         : STEP pulse and direction (1 = positive)
//   position          : signed step count
//   busy              : FSM not idle
//   limit             : requested move is blocked by a soft limit
//   fault             : sticky, both requests seen together
// ---------------------------------------------------------------------------
module motor_step_driver
    import movimiento_pkg::*;
#(
    parameter int PW         = 16,
    parameter int PULSE_W    = 50,
    parameter int DIR_SETUP  = 4,
    parameter int MIN_PERIOD = 100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_pos,
    input  logic          cmd_neg,
    input  logic [PW-1:0] period,
    input  logic [PW-1:0] pos_min,
    input  logic [PW-1:0] pos_max,
    input  logic          zero,
    output logic          step,
    output logic          dir,
    output logic [PW-1:0] position,
    output logic          busy,
    output logic          limit,
    output logic          fault
);

    state_e        state_q, state_d;
    logic          dir_q, dir_d;
    logic          step_q, step_d;
    logic [PW-1:0] position_q, position_d;
    logic          limit_q, limit_d;
    logic          fault_q, fault_d;

    logic          req_p, req_n, blocked_p, blocked_n;
    logic          go_p, go_n;
    logic [PW-1:0] period_eff;
    logic          tmr_clear, tmr_load;
    logic [PW-1:0] tmr_count;
    logic          pulse_done, period_done;

    step_timer #(
        .PW      (PW),
        .PULSE_W (PULSE_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .en          (state_q != S_IDLE),
        .clear       (tmr_clear),
        .load        (tmr_load),
        .period_in   (period_eff),
        .count       (tmr_count),
        .pulse_done  (pulse_done),
        .period_done (period_done)
    );

    always_comb begin
        req_p      = cmd_pos & ~cmd_neg;
        req_n      = cmd_neg & ~cmd_pos;
        blocked_p  = ($signed(position_q) >= $signed(pos_max));
        blocked_n  = ($signed(position_q) <= $signed(pos_min));
        go_p       = req_p & ~blocked_p;
        go_n       = req_n & ~blocked_n;
        period_eff = (period < PW'(MIN_PERIOD)) ? PW'(MIN_PERIOD) : period;
    end

    // Next-state logic. tmr_load marks the cycle on which STEP rises, so it
    // also drives the position update and the period sample.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        tmr_clear = 1'b0;
        tmr_load  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (go_p) begin
                    state_d   = S_SETUP;
                    dir_d     = DIR_POS;
                    tmr_clear = 1'b1;
                end else if (go_n) begin
                    state_d   = S_SETUP;
                    dir_d     = DIR_NEG;
                    tmr_clear = 1'b1;
                end
            end
            S_SETUP: begin
                // Count runs 0..DIR_SETUP, giving the DIR_SETUP+1 cycle latency
                // from the IDLE decision to the STEP rise.
                if (tmr_count == PW'(DIR_SETUP)) begin
                    state_d   = S_PULSE_HI;
                    tmr_clear = 1'b1;
                    tmr_load  = 1'b1;
                end
            end
            S_PULSE_HI: begin
                if (pulse_done) begin
                    state_d = S_PULSE_LO;
                end
            end
            S_PULSE_LO: begin
                // Only a continuation in the same direction skips SETUP;
                // a reversal goes back through IDLE.
                if (period_done) begin
                    if ((dir_q == DIR_POS) ? go_p : go_n) begin
                        state_d   = S_PULSE_HI;
                        tmr_clear = 1'b1;
                        tmr_load  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        step_d     = (state_d == S_PULSE_HI);
        position_d = position_q;
        if (zero) begin
            position_d = '0;
        end else if (tmr_load) begin
            position_d = (dir_q == DIR_POS) ? position_q + PW'(1)
                                            : position_q - PW'(1);
        end
        limit_d = (req_p & blocked_p) | (req_n & blocked_n);
        fault_d = fault_q | (cmd_pos & cmd_neg);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            position_q <= '0;
            limit_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            position_q <= position_d;
            limit_q    <= limit_d;
            fault_q    <= fault_d;
        end
    end

    assign step     = step_q;
    assign dir      = dir_q;
    assign position = position_q;
    assign busy     = (state_q != S_IDLE);
    assign limit    = limit_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_motor_step_driver.sv
// ---------------------------------------------------------------------------
// tb_motor_step_driver
// Directed scenarios plus randomized limit-bounded moves. Expected timing and
// positions come from the STEP/DIR rules: latency DIR_SETUP+1, spacing
// max(period, MIN_PERIOD), PULSE_W high time, one position count per step.
// ---------------------------------------------------------------------------
module tb_motor_step_driver;

    localparam int PW         = 16;
    localparam int PULSE_W    = 50;
    localparam int DIR_SETUP  = 4;
    localparam int MIN_PERIOD = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmdPos = 1'b0;
    logic          cmdNeg = 1'b0;
    logic          zero = 1'b0;
    logic [PW-1:0] period = '0;
    logic [PW-1:0] posMin;
    logic [PW-1:0] posMax;
    logic          step, dir, busy, limit, fault;
    logic [PW-1:0] position;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int modelPos = 0;
    int riseQ[$];
    int riseDir[$];
    int riseAge[$];
    int hiQ[$];

    motor_step_driver #(
        .PW         (PW),
        .PULSE_W    (PULSE_W),
        .DIR_SETUP  (DIR_SETUP),
        .MIN_PERIOD (MIN_PERIOD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_pos  (cmdPos),
        .cmd_neg  (cmdNeg),
        .period   (period),
        .pos_min  (posMin),
        .pos_max  (posMax),
        .zero     (zero),
        .step     (step),
        .dir      (dir),
        .position (position),
        .busy     (busy),
        .limit    (limit),
        .fault    (fault)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Edge index: after posedge k the value is k.
    always @(posedge clk) cyc <= cyc + 1;

    // Pin monitor, sampling 1 unit after each posedge: logs each STEP rise
    // with its edge index, DIR value and how long DIR had been stable, and
    // the high time of each pulse when it falls.
    initial begin : monitor
        logic prevStep;
        logic prevDir;
        int   age;
        int   hiCnt;
        prevStep = 1'b0;
        prevDir  = 1'b0;
        age      = 0;
        hiCnt    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (dir !== prevDir) age = 0;
            else age++;
            if (step === 1'b1 && prevStep === 1'b0) begin
                riseQ.push_back(cyc);
                riseDir.push_back(int'(dir));
                riseAge.push_back(age);
            end
            if (step === 1'b1) begin
                hiCnt++;
            end else if (prevStep === 1'b1) begin
                hiQ.push_back(hiCnt);
                hiCnt = 0;
            end
            prevStep = step;
            prevDir  = dir;
        end
    end

    // Hard stop in case the whole run wedges.
    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int effPeriod(input int p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkPos(input string tag);
        checkOutput(tag, {16'h0, position}, {16'h0, 16'(modelPos)});
    endtask

    task automatic applyStimulus(input logic cp, input logic cn, input logic [PW-1:0] per);
        cmdPos = cp;
        cmdNeg = cn;
        period = per;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitRises(input int target, input int budget, input string tag);
        int k = 0;
        while (riseQ.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput(tag, 32'(riseQ.size() >= target), 32'd1);
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    task automatic strobeZero();
        zero = 1'b1;
        @(negedge clk);
        zero = 1'b0;
        modelPos = 0;
    endtask

    task automatic checkTrain(input int first, input int last, input int gap, input int expDir, input string tag);
        for (int i = first; i <= last; i++) begin
            if (i > first) checkOutput({tag, "_gap"}, 32'(riseQ[i] - riseQ[i-1]), 32'(gap));
            checkOutput({tag, "_width"}, 32'(hiQ[i]), 32'(PULSE_W));
            checkOutput({tag, "_dir"}, 32'(riseDir[i]), 32'(expDir));
        end
    endtask

    initial begin : stimulus
        int base;
        int sampleCyc;
        int startCyc;
        int d, n, per;

        posMin = 16'(-100);
        posMax = 16'(100);

        $display("[TB] reset state");
        waitCycles(3);
        checkOutput("rst_step", 32'(step), 32'd0);
        checkOutput("rst_dir", 32'(dir), 32'd0);
        checkOutput("rst_pos", {16'h0, position}, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_limit", 32'(limit), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        rst = 1'b1;
        waitCycles(2);

        $display("[TB] three positive steps, period 200");
        base = riseQ.size();
        applyStimulus(1'b1, 1'b0, 16'd200);
        sampleCyc = cyc + 1;
        waitRises(base + 3, 700, "t1_rises");
        applyStimulus(1'b0, 1'b0, 16'd200);
        waitIdle(300, "t1_idle");
        modelPos += 3;
        checkOutput("t1_latency", 32'(riseQ[base] - sampleCyc), 32'(DIR_SETUP + 1));
        checkOutput("t1_dir_age", 32'(riseAge[base] >= DIR_SETUP), 32'd1);
        checkTrain(base, base + 2, 200, 1, "t1");
        checkPos("t1_pos");

        $display("[TB] short period clamps to minimum");
        base = riseQ.size();
        applyStimulus(1'b1, 1'b0, 16'd10);
        waitRises(base + 2, 400, "t2_rises");
        applyStimulus(1'b0, 1'b0, 16'd10);
        waitIdle(300, "t2_idle");
        modelPos += 2;
        checkTrain(base, base + 1, effPeriod(10), 1, "t2");
        checkPos("t2_pos");

        $display("[TB] soft upper limit");
        strobeZero();
        checkPos("t3_zero");
        posMax = 16'd2;
        base = riseQ.size();
        applyStimulus(1'b1, 1'b0, 16'd100);
        waitRises(base + 2, 400, "t3_rises");
        waitIdle(300, "t3_idle");
        waitCycles(20);
        modelPos = 2;
        checkOutput("t3_count", 32'(riseQ.size()), 32'(base + 2));
        checkOutput("t3_limit", 32'(limit), 32'd1);
        checkOutput("t3_busy", 32'(busy), 32'd0);
        checkPos("t3_pos");
        posMax = 16'd5;
        waitRises(base + 3, 50, "t3_resume");
        waitIdle(400, "t3_idle2");
        modelPos = 5;
        checkOutput("t3_count2", 32'(riseQ.size()), 32'(base + 5));
        checkOutput("t3_limit2", 32'(limit), 32'd1);
        checkPos("t3_pos2");
        applyStimulus(1'b0, 1'b0, 16'd100);
        waitCycles(2);
        checkOutput("t3_limit_clr", 32'(limit), 32'd0);
        posMax = 16'd100;

        $display("[TB] reversal during STEP high");
        base = riseQ.size();
        applyStimulus(1'b1, 1'b0, 16'd100);
        waitRises(base + 1, 50, "t4_rise1");
        waitCycles(10);
        checkOutput("t4_mid_hi", 32'(step), 32'd1);
        applyStimulus(1'b0, 1'b1, 16'd100);
        waitRises(base + 2, 300, "t4_rise2");
        applyStimulus(1'b0, 1'b0, 16'd100);
        waitIdle(300, "t4_idle");
        modelPos = modelPos + 1 - 1;
        checkOutput("t4_width", 32'(hiQ[base]), 32'(PULSE_W));
        checkOutput("t4_gap", 32'(riseQ[base+1] - riseQ[base]), 32'(effPeriod(100) + DIR_SETUP + 2));
        checkOutput("t4_dir", 32'(riseDir[base+1]), 32'd0);
        checkOutput("t4_dir_age", 32'(riseAge[base+1] >= DIR_SETUP), 32'd1);
        checkPos("t4_pos");

        $display("[TB] conflicting requests");
        base = riseQ.size();
        applyStimulus(1'b1, 1'b1, 16'd100);
        waitCycles(20);
        checkOutput("t5_no_step", 32'(riseQ.size()), 32'(base));
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_fault", 32'(fault), 32'd1);
        applyStimulus(1'b0, 1'b0, 16'd100);
        waitCycles(5);
        checkOutput("t5_fault_sticky", 32'(fault), 32'd1);

        $display("[TB] zero on step rise, async reset mid pulse");
        base = riseQ.size();
        applyStimulus(1'b1, 1'b0, 16'd100);
        startCyc = cyc;
        while (cyc < startCyc + DIR_SETUP + 1) @(negedge clk);
        zero = 1'b1;
        @(negedge clk);
        zero = 1'b0;
        modelPos = 0;
        checkOutput("t6_step_hi", 32'(step), 32'd1);
        checkPos("t6_zero_pos");
        waitRises(base + 2, 150, "t6_rise2");
        modelPos = 1;
        checkPos("t6_pos1");
        waitCycles(5);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        modelPos = 0;
        checkOutput("t6_rst_step", 32'(step), 32'd0);
        checkPos("t6_rst_pos");
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_fault", 32'(fault), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        waitCycles(2);

        $display("[TB] randomized limit-bounded moves");
        for (int it = 0; it < 4; it++) begin
            strobeZero();
            d   = int'($urandom_range(0, 1));
            n   = int'($urandom_range(1, 4));
            per = int'($urandom_range(0, 300));
            if (d == 1) begin
                posMax = 16'(n);
                posMin = 16'(-50);
            end else begin
                posMin = 16'(-n);
                posMax = 16'd50;
            end
            base = riseQ.size();
            applyStimulus(d == 1, d == 0, 16'(per));
            waitRises(base + n, n * 320 + 20, "rnd_rises");
            waitIdle(400, "rnd_idle");
            waitCycles(3);
            modelPos = (d == 1) ? n : -n;
            checkOutput("rnd_count", 32'(riseQ.size()), 32'(base + n));
            checkOutput("rnd_limit", 32'(limit), 32'd1);
            checkPos("rnd_pos");
            checkTrain(base, base + n - 1, effPeriod(per), d, "rnd");
            applyStimulus(1'b0, 1'b0, 16'(per));
            waitCycles(3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
